// File: rtl/dl_seq_pkg.sv
// dl_seq_pkg: shared types and constants for the ROM-load sequencer.
//   dl_state_e   : sequencer states IDLE, LOAD, CLEAR, HOLD, RUN
//   REG_R0..R3   : region indices, 0 is the lowest region
//   SEL_R0..R3   : one-hot region select codes driven on O_ROM_SEL
//   region_sel() : maps a region index to its one-hot select code
package dl_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4
  } dl_state_e;

  localparam logic [1:0] REG_R0 = 2'd0;
  localparam logic [1:0] REG_R1 = 2'd1;
  localparam logic [1:0] REG_R2 = 2'd2;
  localparam logic [1:0] REG_R3 = 2'd3;

  localparam logic [3:0] SEL_R0 = 4'b0001;
  localparam logic [3:0] SEL_R1 = 4'b0010;
  localparam logic [3:0] SEL_R2 = 4'b0100;
  localparam logic [3:0] SEL_R3 = 4'b1000;

  localparam int CNT_W = 20;

  function automatic logic [3:0] region_sel(input logic [1:0] idx);
    logic [3:0] sel;
    case (idx)
      REG_R0:  sel = SEL_R0;
      REG_R1:  sel = SEL_R1;
      REG_R2:  sel = SEL_R2;
      REG_R3:  sel = SEL_R3;
      default: sel = SEL_R0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dl_region_decode.sv
// dl_region_decode: combinational ioctl byte address -> ROM region select and offset.
//   addr_i [18:0] : ioctl byte address
//   sel_o  [3:0]  : one-hot region (0001 below R1_BASE ... 1000 at/above R3_BASE)
//   off_o  [15:0] : address minus the selected region base, low 16 bits
// The range check against the image end is done by the caller.
module dl_region_decode
  import dl_seq_pkg::*;
#(
  parameter logic [18:0] R1_BASE = 19'h04000,
  parameter logic [18:0] R2_BASE = 19'h05000,
  parameter logic [18:0] R3_BASE = 19'h06000
) (
  input  logic [18:0] addr_i,
  output logic [3:0]  sel_o,
  output logic [15:0] off_o
);

  logic [1:0]  idx_s;
  logic [18:0] base_s;

  // Pick the region whose base is the highest one not above the address.
  always_comb begin
    idx_s  = REG_R0;
    base_s = 19'h00000;
    if (addr_i < R1_BASE) begin
      idx_s  = REG_R0;
      base_s = 19'h00000;
    end else if (addr_i < R2_BASE) begin
      idx_s  = REG_R1;
      base_s = R1_BASE;
    end else if (addr_i < R3_BASE) begin
      idx_s  = REG_R2;
      base_s = R2_BASE;
    end else begin
      idx_s  = REG_R3;
      base_s = R3_BASE;
    end
  end

  assign sel_o = region_sel(idx_s);
  assign off_o = 16'(addr_i - base_s);

endmodule

// File: rtl/dl_rom_sequencer.sv
// dl_rom_sequencer: steers the HPS ioctl byte stream into ROM regions, zeroes work RAM
// after a load, holds the core in reset for HOLD_CYCLES clocks, then releases it.
// Optional feature macro: DL_CHECKSUM_EN (8-bit image sum compared with CSUM_EXP).
//   I_CLK, I_RESETn         : clock, synchronous active-low reset
//   I_DL, I_DL_WR           : ioctl_download level, ioctl_wr byte strobe
//   I_DL_ADDR, I_DL_DATA    : ioctl byte address / byte
//   O_ROM_SEL/ADDR/DATA/WE  : one-hot region, offset, data, one-cycle write strobe
//   O_CLR_ADDR, O_CLR_WE    : work-RAM clear address and strobe (data is 0)
//   O_CORE_RESETn           : active-low core reset, released only in RUN
//   O_BUSY, O_ERR, O_CSUM   : not-RUN flag, sticky load error, running image sum
module dl_rom_sequencer
  import dl_seq_pkg::*;
#(
  parameter logic [18:0] R1_BASE     = 19'h04000,
  parameter logic [18:0] R2_BASE     = 19'h05000,
  parameter logic [18:0] R3_BASE     = 19'h06000,
  parameter logic [18:0] ROM_END     = 19'h0C000,
  parameter int          CLR_AW      = 10,
  parameter int          HOLD_CYCLES = 16,
  parameter logic [7:0]  CSUM_EXP    = 8'h00
) (
  input  logic              I_CLK,
  input  logic              I_RESETn,
  input  logic              I_DL,
  input  logic              I_DL_WR,
  input  logic [18:0]       I_DL_ADDR,
  input  logic [7:0]        I_DL_DATA,
  output logic [3:0]        O_ROM_SEL,
  output logic [15:0]       O_ROM_ADDR,
  output logic [7:0]        O_ROM_DATA,
  output logic              O_ROM_WE,
  output logic [CLR_AW-1:0] O_CLR_ADDR,
  output logic              O_CLR_WE,
  output logic              O_CORE_RESETn,
  output logic              O_BUSY,
  output logic              O_ERR,
  output logic [7:0]        O_CSUM
);

  localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [CLR_AW-1:0] CLR_MAX   = {CLR_AW{1'b1}};
  localparam logic [CLR_AW-1:0] CLR_ONE   = {{(CLR_AW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  ROM_END_W = {1'b0, ROM_END};

  dl_state_e         state_q;
  logic              dl_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [15:0]       addr_q;
  logic [7:0]        data_q;
  logic [CLR_AW-1:0] clr_addr_q;
  logic              clr_we_q;
  logic              core_rstn_q;
  logic              busy_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [HOLD_W-1:0] hold_q;

  logic [3:0]  dec_sel_s;
  logic [15:0] dec_off_s;
  logic        rise_s;
  logic        fall_s;
  logic        in_range_s;
  logic        accept_s;
  logic        enter_load_s;
  logic        csum_bad_s;

  dl_region_decode #(
    .R1_BASE (R1_BASE),
    .R2_BASE (R2_BASE),
    .R3_BASE (R3_BASE)
  ) u_decode (
    .addr_i (I_DL_ADDR),
    .sel_o  (dec_sel_s),
    .off_o  (dec_off_s)
  );

  // Edge detect, byte acceptance and the saturating accepted-byte count.
  always_comb begin
    rise_s     = I_DL & ~dl_q;
    fall_s     = ~I_DL & dl_q;
    in_range_s = (I_DL_ADDR < ROM_END);
    accept_s   = (state_q == ST_LOAD) & I_DL_WR & in_range_s;
    if (accept_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 20'd1;
    end else begin
      cnt_d = cnt_q;
    end
    // Every path into LOAD clears the count, the sum and the error flag.
    case (state_q)
      ST_IDLE:  enter_load_s = I_DL;
      ST_CLEAR: enter_load_s = I_DL;
      ST_HOLD:  enter_load_s = I_DL;
      ST_RUN:   enter_load_s = rise_s;
      default:  enter_load_s = 1'b0;
    endcase
  end

`ifdef DL_CHECKSUM_EN
  logic [7:0] csum_q;
  logic [7:0] csum_d;

  // Running sum including a byte accepted in the same cycle as the I_DL fall.
  always_comb begin
    if (accept_s) begin
      csum_d = csum_q + I_DL_DATA;
    end else begin
      csum_d = csum_q;
    end
    csum_bad_s = (csum_d != CSUM_EXP);
  end

  // Image checksum register.
  always_ff @(posedge I_CLK) begin
    if (!I_RESETn) begin
      csum_q <= 8'h00;
    end else if (enter_load_s) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign O_CSUM = csum_q;
`else
  assign csum_bad_s = 1'b0;
  assign O_CSUM     = 8'h00;
`endif

  // Sequencer FSM with all of its registered outputs and counters.
  always_ff @(posedge I_CLK) begin
    if (!I_RESETn) begin
      state_q     <= ST_IDLE;
      dl_q        <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'b0000;
      addr_q      <= 16'h0000;
      data_q      <= 8'h00;
      clr_addr_q  <= {CLR_AW{1'b0}};
      clr_we_q    <= 1'b0;
      core_rstn_q <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
      cnt_q       <= 20'd0;
      hold_q      <= {HOLD_W{1'b0}};
    end else begin
      dl_q <= I_DL;
      we_q <= 1'b0;
      if (enter_load_s) begin
        state_q     <= ST_LOAD;
        clr_we_q    <= 1'b0;
        clr_addr_q  <= {CLR_AW{1'b0}};
        hold_q      <= {HOLD_W{1'b0}};
        core_rstn_q <= 1'b0;
        busy_q      <= 1'b1;
        err_q       <= 1'b0;
        cnt_q       <= 20'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            core_rstn_q <= 1'b0;
            busy_q      <= 1'b1;
          end
          ST_LOAD: begin
            cnt_q <= cnt_d;
            if (I_DL_WR) begin
              if (in_range_s) begin
                we_q   <= 1'b1;
                sel_q  <= dec_sel_s;
                addr_q <= dec_off_s;
                data_q <= I_DL_DATA;
              end else begin
                err_q <= 1'b1;
              end
            end
            if (fall_s) begin
              state_q    <= ST_CLEAR;
              clr_we_q   <= 1'b1;
              clr_addr_q <= {CLR_AW{1'b0}};
              // Length and sum already include a byte written on the falling cycle.
              if ((cnt_d != ROM_END_W) || csum_bad_s) begin
                err_q <= 1'b1;
              end
            end
          end
          ST_CLEAR: begin
            if (clr_addr_q == CLR_MAX) begin
              state_q    <= ST_HOLD;
              clr_we_q   <= 1'b0;
              clr_addr_q <= {CLR_AW{1'b0}};
              hold_q     <= HOLD_INIT;
            end else begin
              clr_addr_q <= clr_addr_q + CLR_ONE;
            end
          end
          ST_HOLD: begin
            if (hold_q == HOLD_ONE) begin
              state_q     <= ST_RUN;
              core_rstn_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              hold_q <= hold_q - HOLD_ONE;
            end
          end
          ST_RUN: begin
            core_rstn_q <= 1'b1;
            busy_q      <= 1'b0;
          end
          default: begin
            state_q     <= ST_IDLE;
            clr_we_q    <= 1'b0;
            core_rstn_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        endcase
      end
    end
  end

  assign O_ROM_SEL     = sel_q;
  assign O_ROM_ADDR    = addr_q;
  assign O_ROM_DATA    = data_q;
  assign O_ROM_WE      = we_q;
  assign O_CLR_ADDR    = clr_addr_q;
  assign O_CLR_WE      = clr_we_q;
  assign O_CORE_RESETn = core_rstn_q;
  assign O_BUSY        = busy_q;
  assign O_ERR         = err_q;

endmodule

// File: tb/tb_dl_rom_sequencer.sv
// tb_dl_rom_sequencer: scoreboard bench for dl_rom_sequencer.
// Expected ROM writes (cycle, select, offset, data) are queued when a byte is driven
// and popped by a negedge monitor when O_ROM_WE appears; clear strobes are tracked too.
module tb_dl_rom_sequencer;

  localparam int CLR_AW = 10;
`ifdef DL_CHECKSUM_EN
  localparam logic [7:0] CSUM_FULL = 8'h5A;
  localparam logic [7:0] CSUM_TWO  = 8'h5A;
`else
  localparam logic [7:0] CSUM_FULL = 8'h00;
  localparam logic [7:0] CSUM_TWO  = 8'h00;
`endif

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  sel;
    logic [15:0] off;
    logic [7:0]  data;
  } exp_t;

  logic              clk;
  logic              rstn;
  logic              dl;
  logic              dl_wr;
  logic [18:0]       dl_addr;
  logic [7:0]        dl_data;
  logic [3:0]        rom_sel;
  logic [15:0]       rom_addr;
  logic [7:0]        rom_data;
  logic              rom_we;
  logic [CLR_AW-1:0] clr_addr;
  logic              clr_we;
  logic              core_rstn;
  logic              busy;
  logic              err;
  logic [7:0]        csum;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   reg_cnt [4];
  int   clr_pulses = 0;
  int   clr_idx = 0;
  exp_t exp_q [$];

  dl_rom_sequencer #(
    .CSUM_EXP (8'h5A)
  ) dut (
    .I_CLK         (clk),
    .I_RESETn      (rstn),
    .I_DL          (dl),
    .I_DL_WR       (dl_wr),
    .I_DL_ADDR     (dl_addr),
    .I_DL_DATA     (dl_data),
    .O_ROM_SEL     (rom_sel),
    .O_ROM_ADDR    (rom_addr),
    .O_ROM_DATA    (rom_data),
    .O_ROM_WE      (rom_we),
    .O_CLR_ADDR    (clr_addr),
    .O_CLR_WE      (clr_we),
    .O_CORE_RESETn (core_rstn),
    .O_BUSY        (busy),
    .O_ERR         (err),
    .O_CSUM        (csum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Independent reference of the region map.
  function automatic exp_t model(input logic [18:0] a, input logic [7:0] d, input int c);
    exp_t        e;
    logic [18:0] t;
    e.cyc  = 32'(c);
    e.data = d;
    if (a < 19'h04000) begin
      e.sel = 4'b0001; t = a;
    end else if (a < 19'h05000) begin
      e.sel = 4'b0010; t = a - 19'h04000;
    end else if (a < 19'h06000) begin
      e.sel = 4'b0100; t = a - 19'h05000;
    end else begin
      e.sel = 4'b1000; t = a - 19'h06000;
    end
    e.off = t[15:0];
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after a rising edge; the write must appear one clock later.
  task automatic wr_byte(input logic [18:0] a, input logic [7:0] d, input bit fall);
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    if (fall) dl = 1'b0;
    if (a < 19'h0C000) exp_q.push_back(model(a, d, cyc + 1));
    step(1);
    dl_wr = 1'b0;
  endtask

  // After a load ends: clear must run 1024 strokes, then 16 held clocks, then release.
  task automatic run_tail(input string tag);
    int gap;
    bit seen;
    bit rel;
    gap  = 0;
    seen = 1'b0;
    rel  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (core_rstn) begin
        rel = 1'b1;
        break;
      end
      if (clr_we) begin
        seen = 1'b1;
        gap  = 0;
      end else if (seen) begin
        gap++;
      end
    end
    check({tag, "_release"}, 64'(rel), 64'd1);
    check({tag, "_clr_count"}, 64'(clr_pulses), 64'd1024);
    check({tag, "_hold_clks"}, 64'(gap), 64'd16);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pop and compare every ROM write, follow the clear address sequence.
  initial begin
    forever begin
      @(negedge clk);
      if (rom_we) begin
        if (exp_q.size() == 0) begin
          check("spurious_we", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rom_wr", {4'h0, 32'(cyc), rom_sel, rom_addr, rom_data}, {4'h0, e});
        end
        case (rom_sel)
          4'b0001: reg_cnt[0]++;
          4'b0010: reg_cnt[1]++;
          4'b0100: reg_cnt[2]++;
          4'b1000: reg_cnt[3]++;
          default: check("rom_sel_onehot", 64'(rom_sel), 64'd0);
        endcase
      end
      if (clr_we) begin
        check("clr_addr", 64'(clr_addr), 64'(clr_idx));
        clr_idx++;
        clr_pulses++;
      end else begin
        clr_idx = 0;
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic [7:0] sum_acc;
    bit         hit;
    rstn    = 1'b0;
    dl      = 1'b0;
    dl_wr   = 1'b0;
    dl_addr = 19'h0;
    dl_data = 8'h00;
    for (int r = 0; r < 4; r++) reg_cnt[r] = 0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_we", 64'(rom_we), 64'd0);
    check("rst_sel", 64'(rom_sel), 64'd0);
    check("rst_addr", 64'(rom_addr), 64'd0);
    check("rst_data", 64'(rom_data), 64'd0);
    check("rst_clr_we", 64'(clr_we), 64'd0);
    check("rst_core_rstn", 64'(core_rstn), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    check("rst_csum", 64'(csum), 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Idle with no download: core stays in reset, nothing written.
    step(100);
    @(negedge clk);
    check("idle_core_rstn", 64'(core_rstn), 64'd0);
    check("idle_busy", 64'(busy), 64'd1);
    check("idle_no_we", 64'(reg_cnt[0] + reg_cnt[1] + reg_cnt[2] + reg_cnt[3]), 64'd0);
    check("idle_no_clr", 64'(clr_pulses), 64'd0);

    // Full image; the last byte coincides with the I_DL fall and fixes the sum to 8'h5A.
    @(posedge clk);
    #1 dl = 1'b1;
    step(1);
    sum_acc = 8'h00;
    for (int a = 0; a < 'hC000; a++) begin
      d = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
      if (a == 'hBFFF) d = 8'h5A - sum_acc;
      sum_acc = sum_acc + d;
      wr_byte(19'(a), d, a == 'hBFFF);
    end
    @(negedge clk);
    check("full_err", 64'(err), 64'd0);
    check("full_csum", 64'(csum), 64'(CSUM_FULL));
    run_tail("full");
    check("full_r0_we", 64'(reg_cnt[0]), 64'h4000);
    check("full_r1_we", 64'(reg_cnt[1]), 64'h1000);
    check("full_r2_we", 64'(reg_cnt[2]), 64'h1000);
    check("full_r3_we", 64'(reg_cnt[3]), 64'h6000);
    check("full_err_run", 64'(err), 64'd0);

    // Short image: length error, core still released, error sticky in RUN.
    dl = 1'b1;
    @(negedge clk);
    check("reload_core_rstn", 64'(core_rstn), 64'd0);
    check("reload_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1 clr_pulses = 0;
    for (int a = 0; a < 'h2000; a++) wr_byte(19'(a), 8'(a) ^ 8'hA5, 1'b0);
    dl = 1'b0;
    step(1);
    @(negedge clk);
    check("short_len_err", 64'(err), 64'd1);
    run_tail("short");
    check("short_err_run", 64'(err), 64'd1);

    // Next load clears ERR; out-of-range byte is dropped and flags ERR.
    dl = 1'b1;
    @(negedge clk);
    check("next_load_err_clr", 64'(err), 64'd0);
    check("next_load_core_rstn", 64'(core_rstn), 64'd0);
    @(posedge clk);
    #1 wr_byte(19'h0C000, 8'hEE, 1'b0);
    @(negedge clk);
    check("range_drop_err", 64'(err), 64'd1);
    @(posedge clk);
    #1 wr_byte(19'h04FFF, 8'h50, 1'b0);
    wr_byte(19'h05000, 8'h0A, 1'b0);
    @(negedge clk);
    check("csum_two_bytes", 64'(csum), 64'(CSUM_TWO));
    @(posedge clk);
    #1 clr_pulses = 0;
    wr_byte(19'h00010, 8'h01, 1'b1);
    @(negedge clk);
    check("third_byte_err", 64'(err), 64'd1);

    // Abort the clear at address 0x123 by raising I_DL.
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (clr_we && (clr_addr == 10'h123)) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reach_0x123", 64'(hit), 64'd1);
    dl = 1'b1;
    @(negedge clk);
    check("abort_clr_stop", 64'(clr_we), 64'd0);
    check("abort_core_rstn", 64'(core_rstn), 64'd0);
    check("abort_busy", 64'(busy), 64'd1);
    check("abort_err_clr", 64'(err), 64'd0);

    // Back in LOAD: one byte with the fall, then the whole tail reruns.
    @(posedge clk);
    #1 clr_pulses = 0;
    wr_byte(19'h0B000, 8'h77, 1'b1);
    run_tail("rerun");
    check("rerun_err", 64'(err), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
